// File: rtl/fifo_pkg.sv
// Shared FIFO defaults: word/pointer widths, depth derivation and threshold defaults.
// Pure constants and a helper function; no logic.
package fifo_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int ADDR_W_DEF    = 4;
   localparam int AE_LEVEL_DEF  = 2;
   localparam int AF_MARGIN_DEF = 2;

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake and status bundle for sync_fifo.
// master = the side driving requests, slave = the FIFO itself.
interface sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read, no reset.
// Read data updates one edge after re_i and otherwise holds.
module fifo_mem #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [(1 << ADDR_W)];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered occupancy count, flags and error pulses.
// Read data one cycle after an accepted read; writes to a full FIFO / reads from an empty one are dropped and flagged.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int AF_LEVEL = fifo_depth(ADDR_W) - AF_MARGIN_DEF,
   parameter int AE_LEVEL = AE_LEVEL_DEF
) (
   input  logic       clk,
   input  logic       rst,
   sync_fifo_if.slave bus
);

   localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AF_CNT   = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_CNT   = AE_LEVEL[ADDR_W:0];

   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, empty_q, afull_q, aempty_q;
   logic              overflow_q, underflow_q;
   logic              rd_valid_q;
   logic              data_ok_q;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] mem_rdata;

   // Acceptance uses only registered flags, so no input reaches an output combinationally.
   always_comb begin
      wr_acc   = bus.wr_en && !full_q;
      rd_acc   = bus.rd_en && !empty_q;
      wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
      count_d  = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + ONE;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         data_ok_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= (count_d == FULL_CNT);
         empty_q     <= (count_d == '0);
         afull_q     <= (count_d >= AF_CNT);
         aempty_q    <= (count_d <= AE_CNT);
         overflow_q  <= bus.wr_en && full_q;
         underflow_q <= bus.rd_en && empty_q;
         rd_valid_q  <= rd_acc;
         if (rd_acc) begin
            data_ok_q <= 1'b1;
         end
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (bus.wr_data),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (mem_rdata)
   );

   // The storage read register has no reset; mask it until a word has been popped since reset.
   assign bus.rd_data      = data_ok_q ? mem_rdata : '0;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

   a_count_matches_ptrs: assert property (
      @(posedge clk) disable iff (!rst) count_q == (wr_ptr_q - rd_ptr_q)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: vector table for fill/drain/error pulses plus hand sequences
// for full-collision, steady-state wrap and asynchronous mid-burst reset.
module tb_sync_fifo;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AFL   = 14;
   localparam int AEL   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sync_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   sync_fifo #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .AF_LEVEL (AFL),
      .AE_LEVEL (AEL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic          wr;
      logic          rd;
      logic [DW-1:0] wd;
      int            cnt;
      bit            ovf;
      bit            udf;
      bit            rv;
      bit            chk;
      logic [DW-1:0] rdat;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_status(input string tag, input int cnt, input bit ovf, input bit udf,
                               input bit rv);
      check({tag, " count"},     32'(bus.count),        32'(cnt));
      check({tag, " full"},      32'(bus.full),         32'(cnt == DEPTH));
      check({tag, " empty"},     32'(bus.empty),        32'(cnt == 0));
      check({tag, " afull"},     32'(bus.almost_full),  32'(cnt >= AFL));
      check({tag, " aempty"},    32'(bus.almost_empty), 32'(cnt <= AEL));
      check({tag, " overflow"},  32'(bus.overflow),     32'(ovf));
      check({tag, " underflow"}, 32'(bus.underflow),    32'(udf));
      check({tag, " rd_valid"},  32'(bus.rd_valid),     32'(rv));
   endtask

   task automatic add(input logic wr, input logic rd, input logic [DW-1:0] wd, input int cnt,
                      input bit ovf, input bit udf, input bit rv, input bit chk,
                      input logic [DW-1:0] rdat);
      vec_t v;
      v.wr = wr; v.rd = rd; v.wd = wd; v.cnt = cnt;
      v.ovf = ovf; v.udf = udf; v.rv = rv; v.chk = chk; v.rdat = rdat;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic wr, input logic rd, input logic [DW-1:0] wd);
      @(negedge clk);
      bus.wr_en   = wr;
      bus.rd_en   = rd;
      bus.wr_data = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.wr_data = '0;

      // Table: fill, overflow, drain, underflow, empty collision, readback.
      for (int k = 1; k <= DEPTH; k++) add(1, 0, 16'(k), k, 0, 0, 0, 0, '0);
      add(1, 0, 16'hDEAD, DEPTH, 1, 0, 0, 0, '0);
      add(0, 0, 16'h0000, DEPTH, 0, 0, 0, 0, '0);
      for (int k = 1; k <= DEPTH; k++) add(0, 1, 16'h0, DEPTH - k, 0, 0, 1, 1, 16'(k));
      add(0, 1, 16'h0000, 0, 0, 1, 0, 1, 16'h0010);
      add(0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0010);
      add(1, 1, 16'hBEEF, 1, 0, 1, 0, 1, 16'h0010);
      add(0, 1, 16'h0000, 0, 0, 0, 1, 1, 16'hBEEF);

      #1 rst = 1'b0;
      #1;
      check_status("reset", 0, 0, 0, 0);
      check("reset rd_data", 32'(bus.rd_data), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vecs[i].wr, vecs[i].rd, vecs[i].wd);
         check_status(tag, vecs[i].cnt, vecs[i].ovf, vecs[i].udf, vecs[i].rv);
         if (vecs[i].chk) check({tag, " rd_data"}, 32'(bus.rd_data), 32'(vecs[i].rdat));
      end

      // Full, then simultaneous write/read: read wins, write is dropped.
      do_reset();
      for (int k = 0; k < DEPTH; k++) drive(1, 0, 16'h0500 + 16'(k));
      check_status("fill16", DEPTH, 0, 0, 0);
      drive(1, 1, 16'hAAAA);
      check_status("fullcoll", DEPTH - 1, 1, 0, 1);
      check("fullcoll rd_data", 32'(bus.rd_data), 32'h0500);
      for (int k = 1; k < DEPTH; k++) begin
         drive(0, 1, 16'h0);
         check($sformatf("fulldrain%0d", k), 32'(bus.rd_data), 32'h0500 + 32'(k));
      end
      check_status("fulldrain end", 0, 0, 0, 1);

      // Steady state at count 5 across pointer wrap.
      do_reset();
      exp_q.delete();
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 16'h0100 + 16'(k));
         exp_q.push_back(16'h0100 + 16'(k));
      end
      for (int j = 0; j < 40; j++) begin
         logic [DW-1:0] w;
         logic [DW-1:0] e;
         w = 16'h0105 + 16'(j);
         exp_q.push_back(w);
         e = exp_q.pop_front();
         drive(1, 1, w);
         check($sformatf("steady%0d count", j), 32'(bus.count), 32'd5);
         check($sformatf("steady%0d rd_valid", j), 32'(bus.rd_valid), 32'd1);
         check($sformatf("steady%0d rd_data", j), 32'(bus.rd_data), 32'(e));
      end

      // Asynchronous reset in the middle of a burst at count 9.
      do_reset();
      for (int k = 0; k < 10; k++) drive(1, 0, 16'h0700 + 16'(k));
      drive(1, 1, 16'h070A);
      drive(0, 0, 16'h0);
      check_status("preburst", 10, 0, 0, 0);
      drive(1, 1, 16'h070B);
      drive(0, 1, 16'h0);
      check_status("midburst", 9, 0, 0, 1);
      check("midburst rd_data", 32'(bus.rd_data), 32'h0702);
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      #2 rst = 1'b0;
      #1;
      check_status("async rst", 0, 0, 0, 0);
      check("async rst rd_data", 32'(bus.rd_data), 32'h0);
      @(posedge clk);
      #1;
      check_status("held rst", 0, 0, 0, 0);
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      rst = 1'b1;
      drive(1, 0, 16'h1234);
      check_status("post wr", 1, 0, 0, 0);
      check("post wr rd_data", 32'(bus.rd_data), 32'h0);
      drive(0, 1, 16'h0);
      check_status("post rd", 0, 0, 0, 1);
      check("post rd rd_data", 32'(bus.rd_data), 32'h1234);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
